// File: rtl/clk_div_monitor.sv
// Measuring end of the divided-clock path: samples an asynchronous divided
// clock in the Clk domain, measures one period and its high time in Clk
// cycles, and flags whether the duty cycle is within tolerance.
module clk_div_monitor #(
    parameter int unsigned CW  = 8,
    parameter int unsigned TOL = 1
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic          clk_in,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          duty_ok,
    output logic          timeout
);

    localparam int unsigned DW      = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [DW-1:0] TOL_W   = DW'(TOL);
    localparam logic [1:0]    WARM_LAST = 2'd2;

    typedef enum logic [2:0] {
        WARM      = 3'd0,
        IDLE      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        REPORT    = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic          s1, s2, s2_d;
    logic          rise;
    logic [1:0]    wcnt, wcnt_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] hcnt, hcnt_nxt;
    logic [CW-1:0] period_nxt, high_nxt;
    logic          busy_nxt, done_nxt, duty_nxt, to_nxt;
    logic [DW-1:0] dbl_high, per_ext, duty_diff;
    logic          duty_within;
    logic          cnt_full;

    assign rise     = s2 & ~s2_d;
    assign cnt_full = (cnt == CNT_MAX);

    // Duty error |2*high - period| at CW+1 bits, using the values about to be latched
    always_comb begin
        dbl_high    = {hcnt, 1'b0};
        per_ext     = {1'b0, cnt};
        duty_diff   = (dbl_high >= per_ext) ? (dbl_high - per_ext) : (per_ext - dbl_high);
        duty_within = (duty_diff <= TOL_W);
    end

    // Two-flop synchroniser plus edge-detect history
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= clk_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WARM;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WARM:      if (wcnt == WARM_LAST) state_nxt = IDLE;
            IDLE:      if (start) state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                if (rise)          state_nxt = MEASURE;
                else if (cnt_full) state_nxt = REPORT;
            end
            MEASURE:   if (rise || cnt_full) state_nxt = REPORT;
            REPORT:    state_nxt = IDLE;
            default:   state_nxt = WARM;
        endcase
    end

    // FSM outputs: counter updates and result latching on entry to REPORT
    always_comb begin
        wcnt_nxt   = wcnt;
        cnt_nxt    = cnt;
        hcnt_nxt   = hcnt;
        period_nxt = period;
        high_nxt   = high_time;
        duty_nxt   = duty_ok;
        to_nxt     = timeout;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt != IDLE);
        case (state)
            WARM: wcnt_nxt = wcnt + 2'd1;
            IDLE: begin
                if (start) begin
                    cnt_nxt  = '0;
                    hcnt_nxt = '0;
                    to_nxt   = 1'b0;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_nxt  = CW'(1);
                    hcnt_nxt = CW'(1);
                end else if (cnt_full) begin
                    done_nxt   = 1'b1;
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    to_nxt     = 1'b1;
                    duty_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            MEASURE: begin
                if (rise) begin
                    done_nxt   = 1'b1;
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    to_nxt     = 1'b0;
                    duty_nxt   = duty_within;
                end else if (cnt_full) begin
                    done_nxt   = 1'b1;
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    to_nxt     = 1'b1;
                    duty_nxt   = 1'b0;
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    hcnt_nxt = hcnt + CW'(s2);
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            duty_ok   <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            wcnt      <= wcnt_nxt;
            cnt       <= cnt_nxt;
            hcnt      <= hcnt_nxt;
            period    <= period_nxt;
            high_time <= high_nxt;
            duty_ok   <= duty_nxt;
            timeout   <= to_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: synchronous clk_in patterns with
// hand-computed period, high time, duty and timeout expectations.
module tb_clk_div_monitor;

    localparam int unsigned CW = 8;

    logic          Clk;
    logic          rst_n;
    logic          clk_in;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          duty_ok;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    // clk_in generator: 0 stuck low, 1 stuck high, 2 high hi_len / low lo_len
    int mode   = 1;
    int hi_len = 1;
    int lo_len = 1;

    clk_div_monitor #(.CW(CW), .TOL(1)) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .clk_in    (clk_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .period    (period),
        .high_time (high_time),
        .duty_ok   (duty_ok),
        .timeout   (timeout)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        int ph;
        ph     = 0;
        clk_in = 1'b1;
        forever begin
            @(negedge Clk);
            case (mode)
                0: clk_in = 1'b0;
                1: clk_in = 1'b1;
                default: begin
                    if (ph >= hi_len + lo_len) ph = 0;
                    clk_in = (ph < hi_len);
                    ph = ph + 1;
                end
            endcase
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   int'(busy), 1);
        check({tag, "_done"},   int'(done), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_high"},   int'(high_time), 0);
        check({tag, "_duty"},   int'(duty_ok), 0);
        check({tag, "_to"},     int'(timeout), 0);
    endtask

    // One measurement; optional stray start after poke cycles of busy
    task automatic run(input string tag, input int m, input int h, input int l,
                       input int exp_p, input int exp_h, input int exp_ok,
                       input int exp_to, input int poke);
        bit seen;
        mode   = m;
        hi_len = h;
        lo_len = l;
        repeat (10) @(negedge Clk);
        pulse_start();
        check({tag, "_busy_after_start"}, int'(busy), 1);
        check({tag, "_to_cleared"}, int'(timeout), 0);
        if (poke > 0) begin
            repeat (poke) @(negedge Clk);
            pulse_start();
        end
        wait_done(seen);
        check({tag, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            check({tag, "_period"}, int'(period), exp_p);
            check({tag, "_high"},   int'(high_time), exp_h);
            check({tag, "_duty"},   int'(duty_ok), exp_ok);
            check({tag, "_to"},     int'(timeout), exp_to);
            check({tag, "_busy_in_report"}, int'(busy), 1);
            @(negedge Clk);
            check({tag, "_done_pulse"}, int'(done), 0);
            check({tag, "_busy_drop"},  int'(busy), 0);
            check({tag, "_period_hold"}, int'(period), exp_p);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1;
        repeat (3) @(negedge Clk);
        check_reset_outputs("rst");

        // Warm-up with clk_in high and start held through the three warm cycles
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        check("warm1_busy", int'(busy), 1);
        check("warm1_done", int'(done), 0);
        @(negedge Clk);
        check("warm2_busy", int'(busy), 1);
        check("warm2_done", int'(done), 0);
        @(negedge Clk);
        start = 1'b0;
        check("warm_end_busy", int'(busy), 0);
        check("warm_end_done", int'(done), 0);
        repeat (3) @(negedge Clk);
        check("warm_start_not_queued", int'(busy), 0);

        run("c5",     2, 2, 3, 5, 2, 1, 0, 0);
        run("h1l4",   2, 1, 4, 5, 1, 0, 0, 0);
        run("c8",     2, 4, 4, 8, 4, 1, 0, 2);
        run("low",    0, 0, 0, 255, 0, 0, 1, 0);
        run("c5_b",   2, 2, 3, 5, 2, 1, 0, 0);
        run("high",   1, 0, 0, 255, 0, 0, 1, 0);
        run("c40",    2, 20, 20, 40, 20, 1, 0, 25);
        run("h3l1",   2, 3, 1, 4, 3, 0, 0, 0);

        // Reset in the middle of a long measurement
        mode   = 2;
        hi_len = 20;
        lo_len = 20;
        repeat (10) @(negedge Clk);
        pulse_start();
        repeat (30) @(negedge Clk);
        check("mid_no_done_yet", int'(done), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge Clk);
        check("midrst_done_held", int'(done), 0);
        rst_n = 1'b1;
        run("post_rst", 2, 2, 3, 5, 2, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Measuring end of the divided-clock path.
- Samples an asynchronous divided clock (e.g. the odd-ratio 50%-duty output of the divider blocks) in the fast Clk domain.
- Measures one full period and the high time in Clk cycles, and flags whether the duty cycle is within tolerance.
- Used in self-test and bring-up to confirm divider ratio and duty after reset or reconfiguration.

Parameters:
- CW, 8: width of the period/high counters and result outputs.
- TOL, 1: allowed |2*high_time - period| for duty_ok.

Ports:
- Clk  input  1  system clock, posedge active.
- rst_n  input  1  asynchronous reset, active-low.
- clk_in  input  1  divided clock under test; asynchronous to Clk.
- start  input  1  one-cycle request to run a single measurement.
- busy  output  1  high from the cycle after an accepted start until done; also high during post-reset warm-up.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- period  output  CW  Clk cycles between two consecutive detected rising edges of clk_in.
- high_time  output  CW  cycles within that period where the synchronised clk_in was 1.
- duty_ok  output  1  |2*high_time - period| <= TOL and not timeout.
- timeout  output  1  measurement aborted by counter saturation.

Behaviour:
- Reset: Clk and rst_n are the single clock and the asynchronous active-low reset, applied to every flop. While rst_n=0:
  - busy=1, done=0, period=0, high_time=0, duty_ok=0, timeout=0.
  - Both synchroniser flops, the edge-detect flop and all counters are 0.
  - FSM is in WARM.
- Synchroniser: 2-flop chain s1->s2. Edge detect: rise = s2 & ~s2_d.
- Latency: a clk_in rising edge appears as rise 2-3 Clk cycles later.
- FSM states: WARM, IDLE, WAIT_RISE, MEASURE, REPORT.
- WARM:
  - Lasts exactly 3 cycles after reset deassertion, then goes to IDLE.
  - busy=1. start is ignored.
  - Purpose: a clk_in held high at reset must never produce a qualified first edge.
- IDLE:
  - busy=0.
  - start=1 -> WAIT_RISE; the wait counter is cleared.
  - Result outputs hold their last values until the next done.
- WAIT_RISE:
  - busy=1. Wait counter increments each cycle.
  - rise -> MEASURE, with cnt=1 and hcnt=1 (the rise cycle counts as high).
  - Wait counter reaches 2^CW-1 with no rise -> REPORT with timeout.
- MEASURE:
  - Each cycle without rise: cnt+=1, hcnt+=s2.
  - rise -> REPORT; latch period=cnt, high_time=hcnt.
  - cnt reaches 2^CW-1 without rise -> REPORT with timeout, period=2^CW-1, high_time=hcnt.
  - Counters never wrap.
- REPORT:
  - One cycle. done=1. period, high_time, duty_ok and timeout are all updated this same cycle.
  - Next state is IDLE; busy drops the following cycle.
- Duty arithmetic: evaluate |2*high_time - period| at CW+1 bits, unsigned, no overflow.
- duty_ok=0 whenever timeout=1.
- timeout is cleared on the next accepted start.
- Boundary and simultaneous-event rules:
  - start while busy (including WARM or REPORT): ignored, not queued.
  - rise in the same cycle start is accepted: not counted. Only rises in WAIT_RISE qualify.
  - clk_in with no low phase (stuck high) or stuck low: timeout path.
  - clk_in faster than Clk/2: results are undefined, but the FSM must always return to IDLE.
  - rst_n asserted mid-measurement: immediate return to reset values; no done pulse.

Test Plan:
- Reset release, clk_in held high, start pulsed in cycles 1-3: busy=1 for 3 cycles; start ignored; no done.
- clk_in synchronous Clk/5 (high 2, low 3), start: done with period=5, high_time=2, duty_ok=1 (|4-5|=1), timeout=0.
- clk_in high 1, low 4: period=5, high_time=1, duty_ok=0 (|2-5|=3).
- clk_in high 4, low 4 (Clk/8): period=8, high_time=4, duty_ok=1.
- clk_in stuck at 0, start: done about 255 cycles later with timeout=1, period=255, duty_ok=0.
- start during MEASURE ignored; rst_n asserted mid-MEASURE -> all outputs 0, busy=1, then a fresh Clk/5 run reports period=5.
